// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result handshake bundle; master is the producer+consumer side, slave is the ALU.
interface alu_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic [3:0]       flags;
  logic             err;

  modport master (
    output in_valid, cmd, a, b, out_ready,
    input  in_ready, out_valid, out, out_hi, flags, err
  );

  modport slave (
    input  in_valid, cmd, a, b, out_ready,
    output in_ready, out_valid, out, out_hi, flags, err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_iter #(parameter int WIDTH = 4) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign done = busy && (cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      cnt     <= '0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      product <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with flags. Define ALU_MUL_EN to build the iterative multiplier;
// without it opcode 111 completes in one cycle with err=1 and zero result.
module alu_seq
  import alu_pkg::*;
#(parameter int WIDTH = 4) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);
  localparam int M = WIDTH - 1;

  state_e state, state_nxt;
  logic   acc_hs, is_mul, mul_busy, mul_done;

  logic [WIDTH-1:0] res, out_q, hi_q;
  logic [WIDTH:0]   sum;
  logic [3:0]       fl, flags_q;
  logic             c, v, err_q;

  assign is_mul        = (bus.cmd == OP_MUL);
  assign bus.in_ready  = (state == ST_IDLE) && !rst && !mul_busy;
  assign acc_hs        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out       = out_q;
  assign bus.out_hi    = hi_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] product;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (acc_hs && is_mul),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
`endif

  // Single-cycle datapath works straight off the presented operands.
  always_comb begin
    res = '0;
    sum = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op_e'(bus.cmd))
      OP_ADD: begin
        sum = {1'b0, bus.a} + {1'b0, bus.b};
        res = sum[M:0];
        c   = sum[WIDTH];
        v   = (bus.a[M] == bus.b[M]) && (res[M] != bus.a[M]);
      end
      OP_SUB: begin
        sum = {1'b0, bus.a} - {1'b0, bus.b};
        res = sum[M:0];
        c   = sum[WIDTH];
        v   = (bus.a[M] != bus.b[M]) && (res[M] != bus.a[M]);
      end
      OP_AND: res = bus.a & bus.b;
      OP_OR:  res = bus.a | bus.b;
      OP_XOR: res = bus.a ^ bus.b;
      OP_SHL: res = (32'(bus.b) >= WIDTH) ? '0 : bus.a << bus.b;
      OP_SHR: res = (32'(bus.b) >= WIDTH) ? '0 : bus.a >> bus.b;
      default: res = '0;
    endcase
    fl         = '0;
    fl[FLAG_N] = res[M];
    fl[FLAG_V] = v;
    fl[FLAG_C] = c;
    fl[FLAG_Z] = (res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (acc_hs) begin
`ifdef ALU_MUL_EN
          state_nxt = is_mul ? ST_BUSY : ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_BUSY: if (mul_done) state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else if (acc_hs) begin
      err_q <= 1'b0;
      if (!is_mul) begin
        out_q   <= res;
        hi_q    <= '0;
        flags_q <= fl;
      end
`ifndef ALU_MUL_EN
      else begin
        out_q   <= '0;
        hi_q    <= '0;
        flags_q <= '0;
        err_q   <= 1'b1;
      end
`endif
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      out_q           <= product[M:0];
      hi_q            <= product[2*WIDTH-1:WIDTH];
      flags_q         <= '0;
      flags_q[FLAG_N] <= product[2*WIDTH-1];
      flags_q[FLAG_Z] <= (product == '0);
    end
`endif
  end
endmodule
